// File: rtl/drw_pkg.sv
// Shared definitions for the drawing VRAM controllers: FSM encoding,
// AXI constants and the ARGB8888 pixel width.
package drw_pkg;

  localparam int PIX_W = 32;

  localparam logic [2:0] AXSIZE_4B   = 3'b010;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETADDR = 3'd1,
    S_WRITE   = 3'd2,
    S_WAITB   = 3'd3,
    S_WAIT    = 3'd4
  } state_t;

endpackage

// File: rtl/drw_vramctrl_wr_if.sv
// AXI4 write-channel bundle (AW/W/B) between the VRAM write controller
// and the interconnect.
interface drw_vramctrl_wr_if;
  import drw_pkg::*;

  // Every channel moves one item on a cycle where VALID and READY are both 1;
  // the master holds VALID and its payload stable until that cycle.
  logic             AWREADY;
  logic             AWVALID;
  logic [31:0]      AWADDR;
  logic [7:0]       AWLEN;
  logic [2:0]       AWSIZE;
  logic             WREADY;
  logic             WVALID;
  logic [PIX_W-1:0] WDATA;
  logic [3:0]       WSTRB;
  logic             WLAST;
  logic             BVALID;
  logic             BREADY;
  logic [1:0]       BRESP;

  modport master (
    output AWVALID, AWADDR, AWLEN, AWSIZE,
    output WVALID, WDATA, WSTRB, WLAST,
    output BREADY,
    input  AWREADY, WREADY, BVALID, BRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWLEN, AWSIZE,
    input  WVALID, WDATA, WSTRB, WLAST,
    input  BREADY,
    output AWREADY, WREADY, BVALID, BRESP
  );

endinterface

// File: rtl/drw_vramctrl_wr.sv
// Drains the pixel write FIFO into VRAM with one AXI4 write burst at a time.
// Optional BRESP checking is enabled by defining DRW_VRAMCTRL_WR_BRESP_CHK_EN.
module drw_vramctrl_wr
  import drw_pkg::*;
(
    input  logic             ACLK,
    input  logic             ARST,
    input  logic             WRT_FIFO_EMPTY,
    input  logic [PIX_W-1:0] WRT_FIFO_DOUT,
    output logic             WRT_FIFO_RD,
    input  logic             ADDR_VALID,
    input  logic [28:0]      DST_ADDR,
    input  logic [7:0]       DST_LEN,
    input  logic             DST_FIN,
    output logic             DST_COMMIT,
    drw_vramctrl_wr_if.master axi,
    output logic             BUSY,
    output logic             WR_ERR,
    output state_t           DBG_STATE
);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       len_q, len_d;
    logic             fin_q, fin_d;

    logic             awvalid, wvalid, wlast, bready, fifo_rd, commit;
    logic [31:0]      awaddr;
    logic [7:0]       awlen;
    logic [PIX_W-1:0] wdata;
    logic             b_hs;

    assign b_hs = (state_q == S_WAITB) && axi.BVALID;

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            len_q   <= 8'd0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            fin_q   <= fin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        fin_d   = fin_q;
        awvalid = 1'b0;
        awaddr  = 32'd0;
        awlen   = 8'd0;
        wvalid  = 1'b0;
        wdata   = '0;
        wlast   = 1'b0;
        bready  = 1'b0;
        fifo_rd = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ADDR_VALID) state_d = S_SETADDR;
            end
            S_SETADDR: begin
                // mkaddr holds its outputs until DST_COMMIT, so AW is driven straight through
                awvalid = 1'b1;
                awaddr  = {3'b000, DST_ADDR};
                awlen   = DST_LEN;
                if (axi.AWREADY) begin
                    commit  = 1'b1;
                    len_d   = DST_LEN;
                    fin_d   = DST_FIN;
                    cnt_d   = 8'd0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // FWFT head is presented directly; it is popped only on a W handshake
                wvalid  = !WRT_FIFO_EMPTY;
                wdata   = WRT_FIFO_DOUT;
                wlast   = (cnt_q == len_q) && wvalid;
                fifo_rd = wvalid && axi.WREADY;
                if (fifo_rd) begin
                    cnt_d = cnt_q + 8'd1;
                    if (wlast) state_d = S_WAITB;
                end
            end
            S_WAITB: begin
                bready = 1'b1;
                if (axi.BVALID) state_d = fin_q ? S_WAIT : S_SETADDR;
            end
            S_WAIT: begin
                // wait for mkaddr to drop its valid so a stale one does not restart us
                if (!ADDR_VALID) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign axi.AWVALID = awvalid;
    assign axi.AWADDR  = awaddr;
    assign axi.AWLEN   = awlen;
    assign axi.AWSIZE  = AXSIZE_4B;
    assign axi.WVALID  = wvalid;
    assign axi.WDATA   = wdata;
    assign axi.WSTRB   = 4'hF;
    assign axi.WLAST   = wlast;
    assign axi.BREADY  = bready;
    assign WRT_FIFO_RD = fifo_rd;
    assign DST_COMMIT  = commit;
    assign BUSY        = (state_q != S_IDLE);
    assign DBG_STATE   = state_q;

`ifdef DRW_VRAMCTRL_WR_BRESP_CHK_EN
    logic        err_q, err_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (b_hs && (axi.BRESP != RESP_OKAY)) begin
            err_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            err_q     <= 1'b0;
            err_cnt_q <= 16'd0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign WR_ERR = err_q;
`else
    logic unused_bresp;
    assign unused_bresp = ^{axi.BRESP, b_hs};
    assign WR_ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_drw_vramctrl_wr.sv
// Bench for drw_vramctrl_wr: cycle vector table plus model-driven burst sequences.
`timescale 1ns/1ps
module tb_drw_vramctrl_wr;
  import drw_pkg::*;

`ifdef DRW_VRAMCTRL_WR_BRESP_CHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [31:0] fifo_dout;
  logic        fifo_rd;
  logic        addr_valid;
  logic [28:0] dst_addr;
  logic [7:0]  dst_len;
  logic        dst_fin;
  logic        dst_commit;
  logic        busy;
  logic        wr_err;
  state_t      dbg_state;

  drw_vramctrl_wr_if axi();

  drw_vramctrl_wr dut (
    .ACLK(clk), .ARST(rst),
    .WRT_FIFO_EMPTY(fifo_empty), .WRT_FIFO_DOUT(fifo_dout), .WRT_FIFO_RD(fifo_rd),
    .ADDR_VALID(addr_valid), .DST_ADDR(dst_addr), .DST_LEN(dst_len), .DST_FIN(dst_fin),
    .DST_COMMIT(dst_commit), .axi(axi), .BUSY(busy), .WR_ERR(wr_err), .DBG_STATE(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- mkaddr / FIFO / AXI slave model ----------------
  int          n_cmd, cmd_idx;
  logic [28:0] cmd_addr[4];
  logic [7:0]  cmd_len[4];
  logic        cmd_fin[4];
  logic [1:0]  cmd_resp[4];
  bit          av_hold, wr_rand, b_pending, bub_now;
  int          aw_stall, aw_wait, bubble_at, bubble_left, b_idx;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int          beat, cur_len, n_aw, n_b, n_beats, n_commit, stall_seen;
  bit          s_rd, s_commit, s_wlast_hs, s_b_hs, s_aw_wait;

  function automatic int cidx();
    return (cmd_idx < n_cmd) ? cmd_idx : n_cmd - 1;
  endfunction

  task automatic drive_model();
    addr_valid    = (cmd_idx < n_cmd) || av_hold;
    dst_addr      = cmd_addr[cidx()];
    dst_len       = cmd_len[cidx()];
    dst_fin       = cmd_fin[cidx()];
    axi.AWREADY   = (aw_wait >= aw_stall);
    axi.WREADY    = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    bub_now       = (bubble_left > 0) && (beat == bubble_at);
    fifo_empty    = bub_now || (fifo_q.size() == 0);
    fifo_dout     = (fifo_q.size() != 0) ? fifo_q[0] : 32'd0;
    axi.BVALID    = b_pending;
    axi.BRESP     = b_pending ? cmd_resp[b_idx] : RESP_OKAY;
  endtask

  task automatic monitor();
    if (axi.AWVALID) begin
      chk("aw_addr", axi.AWADDR, {3'b000, cmd_addr[cidx()]});
      chk("aw_len", {24'd0, axi.AWLEN}, {24'd0, cmd_len[cidx()]});
      if (axi.AWREADY) begin
        chk("aw_one_outstanding", n_aw, n_b);
        n_aw++;
        cur_len = cmd_len[cidx()];
        beat = 0;
      end else begin
        stall_seen++;
        chk("commit_during_stall", dst_commit, 0);
      end
    end
    if (dst_commit) n_commit++;
    if (fifo_empty) chk("wvalid_when_empty", axi.WVALID, 0);
    if (axi.WVALID) begin
      if (exp_q.size() == 0) chk("exp_underflow", 1, 0);
      else chk("wdata", axi.WDATA, exp_q[0]);
      chk("wstrb", axi.WSTRB, 4'hF);
      if (axi.WREADY) begin
        beat++;
        n_beats++;
        chk("wlast", axi.WLAST, beat == cur_len + 1);
        chk("fifo_rd_on_hs", fifo_rd, 1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        chk("fifo_rd_no_hs", fifo_rd, 0);
      end
    end
    s_rd       = fifo_rd;
    s_commit   = dst_commit;
    s_aw_wait  = axi.AWVALID && !axi.AWREADY;
    s_wlast_hs = axi.WVALID && axi.WREADY && axi.WLAST;
    s_b_hs     = axi.BVALID && axi.BREADY;
    if (s_b_hs) n_b++;
  endtask

  task automatic update();
    if (s_rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (s_commit) begin
      cmd_idx++;
      aw_wait = 0;
    end
    if (s_aw_wait) aw_wait++;
    if (s_wlast_hs) b_pending = 1'b1;
    if (s_b_hs) begin
      b_pending = 1'b0;
      b_idx++;
    end
    if (bub_now) bubble_left--;
    drive_model();
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    update();
  endtask

  task automatic setup(input int n);
    n_cmd = n; cmd_idx = 0; av_hold = 1'b1; wr_rand = 1'b0; b_pending = 1'b0;
    aw_stall = 0; aw_wait = 0; bubble_at = -1; bubble_left = 0; b_idx = 0;
    beat = 0; cur_len = 0; n_aw = 0; n_b = 0; n_beats = 0; n_commit = 0; stall_seen = 0;
    fifo_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      cmd_addr[i] = '0; cmd_len[i] = '0; cmd_fin[i] = 1'b0; cmd_resp[i] = RESP_OKAY;
    end
  endtask

  task automatic push_words(input int n, input logic [7:0] tag);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back({8'hC0, tag, 16'(i)});
      exp_q.push_back({8'hC0, tag, 16'(i)});
    end
  endtask

  task automatic run_until_b(input int nb, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (n_b >= nb) break;
      cycle();
    end
    chk("b_count_in_budget", n_b, nb);
  endtask

  // Called at posedge+1 right after the final B handshake, with ADDR_VALID still held.
  task automatic finish_cmd(input int beats);
    chk("state_wait", dbg_state, S_WAIT);
    chk("busy_in_wait", busy, 1);
    chk("beats", n_beats, beats);
    chk("commits", n_commit, n_cmd);
    chk("aw_count", n_aw, n_cmd);
    chk("exp_q_drained", exp_q.size(), 0);
    av_hold = 1'b0;
    drive_model();
    @(posedge clk);
    #1;
    chk("busy_falls", busy, 0);
    chk("state_idle", dbg_state, S_IDLE);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic av, empty, awready, wready, bvalid;
    state_t st;
    logic awvalid, commit, wvalid, wlast, rd, bready, busy;
  } vec_t;

  vec_t vt[12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b1;
    fifo_empty = 1'b1; fifo_dout = '0; addr_valid = 1'b0;
    dst_addr = '0; dst_len = '0; dst_fin = 1'b0;
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0; axi.BRESP = RESP_OKAY;
    setup(1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_busy", busy, 0);
    chk("rst_awvalid", axi.AWVALID, 0);
    chk("rst_awaddr", axi.AWADDR, 0);
    chk("rst_awsize", axi.AWSIZE, 3'b010);
    chk("rst_wstrb", axi.WSTRB, 4'hF);
    chk("rst_wvalid", axi.WVALID, 0);
    chk("rst_wdata", axi.WDATA, 0);
    chk("rst_bready", axi.BREADY, 0);
    chk("rst_commit", dst_commit, 0);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_wr_err", wr_err, 0);
    rst = 1'b0;

    // single-beat burst (len 0) walked one cycle at a time
    //          av  emp awr wr  bv  state      awv cmt wv  wl  rd  br  busy
    vt[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, S_IDLE,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    vt[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, S_IDLE,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    vt[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, S_SETADDR, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
    vt[3]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, S_SETADDR, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1};
    vt[4]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, S_WRITE,   1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
    vt[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, S_WRITE,   1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1};
    vt[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, S_WRITE,   1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1};
    vt[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, S_WAITB,   1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};
    vt[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, S_WAITB,   1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};
    vt[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, S_WAIT,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
    vt[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0, S_WAIT,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
    vt[11] = '{1'b0,1'b1,1'b0,1'b0,1'b0, S_IDLE,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    @(posedge clk);
    #1;
    dst_addr = 29'h40; dst_len = 8'd0; dst_fin = 1'b1; fifo_dout = 32'hA5A5_0001;
    for (int i = 0; i < 12; i++) begin
      addr_valid = vt[i].av; fifo_empty = vt[i].empty; axi.AWREADY = vt[i].awready;
      axi.WREADY = vt[i].wready; axi.BVALID = vt[i].bvalid; axi.BRESP = RESP_OKAY;
      @(negedge clk);
      chk($sformatf("v%0d_state", i), dbg_state, vt[i].st);
      chk($sformatf("v%0d_awvalid", i), axi.AWVALID, vt[i].awvalid);
      chk($sformatf("v%0d_awaddr", i), axi.AWADDR, vt[i].awvalid ? 32'h40 : 32'h0);
      chk($sformatf("v%0d_commit", i), dst_commit, vt[i].commit);
      chk($sformatf("v%0d_wvalid", i), axi.WVALID, vt[i].wvalid);
      chk($sformatf("v%0d_wdata", i), axi.WDATA, (vt[i].st == S_WRITE) ? 32'hA5A5_0001 : 32'h0);
      chk($sformatf("v%0d_wlast", i), axi.WLAST, vt[i].wlast);
      chk($sformatf("v%0d_fifo_rd", i), fifo_rd, vt[i].rd);
      chk($sformatf("v%0d_bready", i), axi.BREADY, vt[i].bready);
      chk($sformatf("v%0d_busy", i), busy, vt[i].busy);
      @(posedge clk);
      #1;
    end

    // single burst, len 3
    setup(1);
    cmd_addr[0] = 29'h100; cmd_len[0] = 8'd3; cmd_fin[0] = 1'b1;
    push_words(4, 8'h01);
    drive_model();
    run_until_b(1, 200);
    finish_cmd(4);

    // three bursts of 8 beats, FIN on the last
    setup(3);
    for (int i = 0; i < 3; i++) begin
      cmd_addr[i] = 29'h1000 + 29'(i * 32); cmd_len[i] = 8'd7; cmd_fin[i] = (i == 2);
    end
    push_words(24, 8'h02);
    drive_model();
    run_until_b(3, 500);
    finish_cmd(24);

    // FIFO bubble after beat 2 plus random WREADY
    setup(1);
    cmd_addr[0] = 29'h0ABC_DE0; cmd_len[0] = 8'd7; cmd_fin[0] = 1'b1;
    push_words(8, 8'h03);
    bubble_at = 2; bubble_left = 5; wr_rand = 1'b1;
    drive_model();
    run_until_b(1, 500);
    chk("bubble_consumed", bubble_left, 0);
    finish_cmd(8);

    // AWREADY held low for 10 cycles
    setup(1);
    cmd_addr[0] = 29'h1FFF_FFC0; cmd_len[0] = 8'd1; cmd_fin[0] = 1'b1;
    push_words(2, 8'h04);
    aw_stall = 10;
    drive_model();
    run_until_b(1, 200);
    chk("aw_stall_cycles", stall_seen, 10);
    finish_cmd(2);

    // SLVERR on burst 1, OKAY on burst 2
    setup(2);
    cmd_addr[0] = 29'h200; cmd_len[0] = 8'd1; cmd_fin[0] = 1'b0; cmd_resp[0] = RESP_SLVERR;
    cmd_addr[1] = 29'h208; cmd_len[1] = 8'd1; cmd_fin[1] = 1'b1; cmd_resp[1] = RESP_OKAY;
    push_words(4, 8'h05);
    drive_model();
    chk("wr_err_before", wr_err, 0);
    run_until_b(1, 200);
    chk("wr_err_after_slverr", wr_err, ERR_EN);
    run_until_b(2, 200);
    chk("wr_err_sticky", wr_err, ERR_EN);
    finish_cmd(4);
    chk("wr_err_idle", wr_err, ERR_EN);

    // async reset after beat 2 of an 8-beat burst
    setup(1);
    cmd_addr[0] = 29'h300; cmd_len[0] = 8'd7; cmd_fin[0] = 1'b1;
    push_words(8, 8'h06);
    drive_model();
    for (int i = 0; i < 200; i++) begin
      if (n_beats >= 2) break;
      cycle();
    end
    chk("beats_before_rst", n_beats, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", dbg_state, S_IDLE);
    chk("arst_busy", busy, 0);
    chk("arst_wvalid", axi.WVALID, 0);
    chk("arst_wlast", axi.WLAST, 0);
    chk("arst_fifo_rd", fifo_rd, 0);
    chk("arst_awvalid", axi.AWVALID, 0);
    chk("arst_wr_err", wr_err, 0);
    setup(1);
    cmd_addr[0] = 29'h400; cmd_len[0] = 8'd2; cmd_fin[0] = 1'b1;
    push_words(3, 8'h07);
    drive_model();
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive_model();
    run_until_b(1, 200);
    finish_cmd(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
